// File: rtl/imm_extend_pipe.sv
// Pipelined immediate generator between decode and execute.
// A 2-entry main/skid buffer keeps in_ready driven purely from registered occupancy.
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SHIFT = 2,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic [1:0]       out_mode
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]       count_reg, count_next;
  logic [OUT_W-1:0] main_imm_reg, skid_imm_reg;
  logic [TAG_W-1:0] main_tag_reg, skid_tag_reg;
  logic [1:0]       main_mode_reg, skid_mode_reg;

  logic [OUT_W-1:0] sext, zext, upper, ext_imm;
  logic             in_fire, out_fire;
  logic             load_main_in, load_main_skid, load_skid;

  // Bitwise construction avoids zero-width replications when OUT_W == IN_W.
  for (genvar gi = 0; gi < OUT_W; gi++) begin : g_ext
    if (gi < IN_W) begin : g_low
      assign sext[gi] = in_imm[gi];
      assign zext[gi] = in_imm[gi];
    end else begin : g_high
      assign sext[gi] = in_imm[IN_W-1];
      assign zext[gi] = 1'b0;
    end
    if (gi >= OUT_W - IN_W) begin : g_up
      assign upper[gi] = in_imm[gi-(OUT_W-IN_W)];
    end else begin : g_up_zero
      assign upper[gi] = 1'b0;
    end
  end

  always_comb begin
    ext_imm = sext;
    case (in_mode)
      2'b00:   ext_imm = sext;
      2'b01:   ext_imm = zext;
      2'b10:   ext_imm = sext << SHIFT;
      default: ext_imm = upper;
    endcase
  end

  // State and data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg     <= EMPTY;
      main_imm_reg  <= '0;
      main_tag_reg  <= '0;
      main_mode_reg <= '0;
      skid_imm_reg  <= '0;
      skid_tag_reg  <= '0;
      skid_mode_reg <= '0;
    end else begin
      count_reg <= count_next;
      if (load_main_in) begin
        main_imm_reg  <= ext_imm;
        main_tag_reg  <= in_tag;
        main_mode_reg <= in_mode;
      end else if (load_main_skid) begin
        main_imm_reg  <= skid_imm_reg;
        main_tag_reg  <= skid_tag_reg;
        main_mode_reg <= skid_mode_reg;
      end
      if (load_skid) begin
        skid_imm_reg  <= ext_imm;
        skid_tag_reg  <= in_tag;
        skid_mode_reg <= in_mode;
      end
    end
  end

  // Next-state and load enables.
  always_comb begin
    in_fire        = in_valid & in_ready;
    out_fire       = out_valid & out_ready;
    count_next     = count_reg;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (count_reg)
      EMPTY: begin
        if (in_fire) begin
          load_main_in = 1'b1;
          count_next   = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          load_main_in = 1'b1;
        end else if (out_fire) begin
          count_next = EMPTY;
        end else if (in_fire) begin
          load_skid  = 1'b1;
          count_next = TWO;
        end
      end
      TWO: begin
        if (out_fire) begin
          load_main_skid = 1'b1;
          count_next     = ONE;
        end
      end
      default: count_next = EMPTY;
    endcase
  end

  // Outputs derive only from registered state.
  always_comb begin
    in_ready  = (count_reg != TWO);
    out_valid = (count_reg != EMPTY);
    out_imm   = main_imm_reg;
    out_tag   = main_tag_reg;
    out_mode  = main_mode_reg;
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: default instance plus a
// narrow-parameter instance (IN_W=12, OUT_W=20, SHIFT=1).
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_imm = '0;
  logic [1:0]  in_mode = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_imm;
  logic [4:0]  out_tag;
  logic [1:0]  out_mode;

  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [11:0] b_in_imm = '0;
  logic [1:0]  b_in_mode = '0;
  logic [4:0]  b_in_tag = '0;
  logic        b_out_valid;
  logic        b_out_ready = 1'b1;
  logic [19:0] b_out_imm;
  logic [4:0]  b_out_tag;
  logic [1:0]  b_out_mode;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] imm;
    logic [4:0]  tag;
    logic [1:0]  mode;
  } exp_t;

  exp_t        exp_q[$];
  logic [19:0] exp2_q[$];

  int          model_cnt = 0;
  bit          hold_pending = 0;
  logic [31:0] prev_imm;
  logic [4:0]  prev_tag;
  logic [1:0]  prev_mode;
  bit          stream_done = 0;

  imm_extend_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm),
    .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_tag(out_tag), .out_mode(out_mode)
  );

  imm_extend_pipe #(.IN_W(12), .OUT_W(20), .SHIFT(1), .TAG_W(5)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_imm(b_in_imm),
    .in_mode(b_in_mode), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_imm(b_out_imm),
    .out_tag(b_out_tag), .out_mode(b_out_mode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference extension for IN_W=16, OUT_W=32, SHIFT=2.
  function automatic logic [31:0] model(input logic [15:0] imm, input logic [1:0] mode);
    int s;
    s = $signed(imm);
    case (mode)
      2'd0:    return 32'(s);
      2'd1:    return {16'h0000, imm};
      2'd2:    return 32'(s * 4);
      default: return {imm, 16'h0000};
    endcase
  endfunction

  task automatic drive_beat(input logic [15:0] imm, input logic [1:0] mode,
                            input logic [4:0] tag, input logic [31:0] exp_imm);
    int  waited = 0;
    bit  done = 0;
    in_valid = 1'b1;
    in_imm   = imm;
    in_mode  = mode;
    in_tag   = tag;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back('{exp_imm, tag, mode});
        done = 1;
      end else if (++waited > 50) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: tag %0d not accepted, expected acceptance within 50 cycles", tag);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || exp2_q.size() != 0) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", 64'(exp_q.size() + exp2_q.size()), 64'd0);
  endtask

  // Monitor: occupancy model, FIFO scoreboard, and hold stability.
  always @(negedge clk) begin
    if (rst) begin
      model_cnt    = 0;
      hold_pending = 0;
    end else begin
      chk("in_ready_vs_count", 64'(in_ready), 64'(model_cnt != 2));
      chk("out_valid_vs_count", 64'(out_valid), 64'(model_cnt != 0));
      if (hold_pending) begin
        chk("hold_imm", 64'(out_imm), 64'(prev_imm));
        chk("hold_tag", 64'(out_tag), 64'(prev_tag));
        chk("hold_mode", 64'(out_mode), 64'(prev_mode));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got tag %0d imm 0x%0h, expected no beat", out_tag, out_imm);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          $display("beat tag=%0d mode=%0d imm=0x%08h (expected 0x%08h)", out_tag, out_mode, out_imm, e.imm);
          chk("out_imm", 64'(out_imm), 64'(e.imm));
          chk("out_tag", 64'(out_tag), 64'(e.tag));
          chk("out_mode", 64'(out_mode), 64'(e.mode));
        end
      end
      hold_pending = out_valid && !out_ready;
      prev_imm  = out_imm;
      prev_tag  = out_tag;
      prev_mode = out_mode;
      model_cnt = model_cnt + int'(in_valid && in_ready) - int'(out_valid && out_ready);
    end
  end

  always @(negedge clk) begin
    if (!rst && b_out_valid && b_out_ready) begin
      if (exp2_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL p2_unexpected_output: got imm 0x%0h, expected no beat", b_out_imm);
      end else begin
        logic [19:0] e2;
        e2 = exp2_q.pop_front();
        $display("p2 beat tag=%0d imm=0x%05h (expected 0x%05h)", b_out_tag, b_out_imm, e2);
        chk("p2_out_imm", 64'(b_out_imm), 64'(e2));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_imm", 64'(out_imm), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_out_mode", 64'(out_mode), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Four modes back to back
    out_ready = 1'b1;
    drive_beat(16'h8001, 2'd0, 5'd1, 32'hFFFF8001);
    drive_beat(16'h8001, 2'd1, 5'd2, 32'h00008001);
    drive_beat(16'h8001, 2'd2, 5'd3, 32'hFFFE0004);
    drive_beat(16'h1234, 2'd3, 5'd4, 32'h12340000);
    drive_beat(16'h7FFF, 2'd0, 5'd5, 32'h00007FFF);
    drive_beat(16'h7FFF, 2'd2, 5'd6, 32'h0001FFFC);
    wait_drain();

    // Backpressure: 7 and 8 fill the buffer, 9 waits
    out_ready = 1'b0;
    drive_beat(16'h00A7, 2'd1, 5'd7, 32'h000000A7);
    drive_beat(16'h00A8, 2'd1, 5'd8, 32'h000000A8);
    fork
      drive_beat(16'h00A9, 2'd1, 5'd9, 32'h000000A9);
      begin
        @(negedge clk);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        chk("bp_hold_tag7", 64'(out_tag), 64'd7);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Streaming with random backpressure
    fork
      begin
        for (int i = 0; i < 64; i++) begin
          logic [15:0] r_imm;
          logic [1:0]  r_mode;
          r_imm  = 16'($urandom);
          r_mode = 2'($urandom_range(0, 3));
          drive_beat(r_imm, r_mode, 5'(i), model(r_imm, r_mode));
        end
        stream_done = 1;
      end
      begin
        while (!stream_done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();

    // Mid-operation reset with a full buffer
    out_ready = 1'b0;
    drive_beat(16'h1111, 2'd0, 5'd10, 32'h00001111);
    drive_beat(16'h2222, 2'd0, 5'd11, 32'h00002222);
    chk("full_in_ready_low", 64'(in_ready), 64'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_in_ready", 64'(in_ready), 64'd1);
    chk("async_rst_out_imm", 64'(out_imm), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    drive_beat(16'hFFFF, 2'd0, 5'd12, 32'hFFFFFFFF);
    wait_drain();

    // Narrow-parameter instance
    b_in_valid = 1'b1;
    b_in_imm   = 12'h800;
    b_in_mode  = 2'd2;
    b_in_tag   = 5'd1;
    @(negedge clk);
    chk("p2_in_ready", 64'(b_in_ready), 64'd1);
    exp2_q.push_back(20'hFF000);
    @(posedge clk);
    #1;
    b_in_mode = 2'd3;
    b_in_tag  = 5'd2;
    @(negedge clk);
    chk("p2_in_ready2", 64'(b_in_ready), 64'd1);
    exp2_q.push_back(20'h80000);
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    wait_drain();

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
